// File: rtl/cnn1d_frame_sequencer_pkg.sv
// Shared constants and FSM state type for the 1-D CNN frame sequencer.
package cnn1d_pkg;

  localparam int DW        = 4;              // pixel / tap width
  localparam int KW        = 3;              // filter taps per output
  localparam int NOUT      = 5;              // outputs per frame
  localparam int NIMG      = NOUT + KW - 1;  // image pixels per frame
  localparam int RW        = 10;             // result width
  localparam int NPROD     = KW * NOUT;      // CNN register-file depth (15)
  localparam int NBEAT     = KW + NIMG;      // input beats per frame (10)
  localparam int FLUSH_CYC = 2;              // RF read register + adder register

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/cnn1d_frame_sequencer_if.sv
// Input stream, CNN datapath bus and result stream of the frame sequencer.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. Once valid is raised, the source holds data (and last) stable
// until that transfer; ready may change freely and carries no data.
interface cnn1d_frame_sequencer_if;
  import cnn1d_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  logic          cnn_start;
  logic [DW-1:0] cnn_image;
  logic [DW-1:0] cnn_filter;
  logic          cnn_read_en;
  logic [RW-1:0] conv_result;

  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic          res_last;

  // Sequencer side.
  modport master (
    input  in_valid, in_data, conv_result, res_ready,
    output in_ready, cnn_start, cnn_image, cnn_filter, cnn_read_en,
           res_valid, res_data, res_last
  );

  // Environment side: frame source, CNN datapath and result sink.
  modport slave (
    output in_valid, in_data, conv_result, res_ready,
    input  in_ready, cnn_start, cnn_image, cnn_filter, cnn_read_en,
           res_valid, res_data, res_last
  );
endinterface

// File: rtl/cnn1d_result_buffer.sv
// Captures the five CNN results at their pipeline latency and drains them
// over the result stream.
module cnn1d_result_buffer
  import cnn1d_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          read_en,
  input  logic [RW-1:0] conv_result,
  input  logic          drain,
  input  logic          res_ready,
  output logic          res_valid,
  output logic [RW-1:0] res_data,
  output logic          res_last,
  output logic          drain_done
);

  logic          d1;
  logic          d2;
  logic [2:0]    cap_idx;
  logic [2:0]    out_idx;
  logic [RW-1:0] res_buf [NOUT];

  // Delay read_en by two cycles so capture lines up with the adder output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1      <= 1'b0;
      d2      <= 1'b0;
      cap_idx <= '0;
      for (int i = 0; i < NOUT; i++) res_buf[i] <= '0;
    end else begin
      d1 <= read_en;
      d2 <= d1;
      if (d2) begin
        res_buf[cap_idx] <= conv_result;
        cap_idx          <= (cap_idx == 3'(NOUT - 1)) ? 3'd0 : cap_idx + 3'd1;
      end
    end
  end

  // Drain pointer advances on each accepted result, wrapping after y[4].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_idx <= '0;
    end else if (res_valid && res_ready) begin
      out_idx <= res_last ? 3'd0 : out_idx + 3'd1;
    end
  end

  assign res_valid  = drain;
  assign res_data   = drain ? res_buf[out_idx] : '0;
  assign res_last   = drain && (out_idx == 3'(NOUT - 1));
  assign drain_done = res_valid && res_ready && res_last;

endmodule

// File: rtl/cnn1d_frame_sequencer.sv
// Frame sequencer: loads taps/pixels, drives 15 write and 5 read cycles into
// the CNN datapath, then returns the captured results.
module cnn1d_frame_sequencer
  import cnn1d_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  cnn1d_frame_sequencer_if.master        bus,
  output logic                           busy,
  output state_t                         dbg_state
);

  state_t        state, state_next;
  logic [3:0]    beat;
  logic [1:0]    wr_k, wr_k_next;
  logic [2:0]    wr_j, wr_j_next;
  logic [2:0]    ph_cnt, ph_cnt_next;
  logic [2:0]    pix_idx;
  logic [2:0]    pix_wr;
  logic          accept;
  logic          draining;
  logic          drain_done;
  logic [DW-1:0] tap [KW];
  logic [DW-1:0] pix [NIMG];
  logic          start_q;
  logic          read_en_q;
  logic [DW-1:0] image_q;
  logic [DW-1:0] filter_q;

  assign accept   = (state == LOAD) && bus.in_valid;
  assign draining = (state == DRAIN);
  // Pixel slot for beats 3..9; modulo-8 subtraction lands on 0..6.
  assign pix_wr   = beat[2:0] - 3'(KW);
  assign pix_idx  = wr_j_next + {1'b0, wr_k_next};

  // Next-state and WRITE/READ/FLUSH counter sequencing.
  always_comb begin
    state_next  = state;
    wr_k_next   = wr_k;
    wr_j_next   = wr_j;
    ph_cnt_next = ph_cnt;
    case (state)
      LOAD: begin
        if (accept && beat == 4'(NBEAT - 1)) begin
          state_next = WRITE;
          wr_k_next  = '0;
          wr_j_next  = '0;
        end
      end
      WRITE: begin
        if (wr_k == 2'(KW - 1)) begin
          wr_k_next = '0;
          if (wr_j == 3'(NOUT - 1)) begin
            state_next  = READ;
            ph_cnt_next = '0;
          end else begin
            wr_j_next = wr_j + 3'd1;
          end
        end else begin
          wr_k_next = wr_k + 2'd1;
        end
      end
      READ: begin
        if (ph_cnt == 3'(NOUT - 1)) begin
          state_next  = FLUSH;
          ph_cnt_next = '0;
        end else begin
          ph_cnt_next = ph_cnt + 3'd1;
        end
      end
      FLUSH: begin
        if (ph_cnt == 3'(FLUSH_CYC - 1)) begin
          state_next  = DRAIN;
          ph_cnt_next = '0;
        end else begin
          ph_cnt_next = ph_cnt + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_done) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // State, counters, and CNN outputs registered from the next-cycle view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      wr_k      <= '0;
      wr_j      <= '0;
      ph_cnt    <= '0;
      start_q   <= 1'b0;
      read_en_q <= 1'b0;
      image_q   <= '0;
      filter_q  <= '0;
    end else begin
      state     <= state_next;
      wr_k      <= wr_k_next;
      wr_j      <= wr_j_next;
      ph_cnt    <= ph_cnt_next;
      start_q   <= (state_next == WRITE);
      read_en_q <= (state_next == READ);
      image_q   <= (state_next == WRITE) ? pix[pix_idx] : '0;
      filter_q  <= (state_next == WRITE) ? tap[wr_k_next] : '0;
    end
  end

  // Beat counter and tap/pixel stores, written only on input handshakes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
      for (int i = 0; i < KW; i++)   tap[i] <= '0;
      for (int i = 0; i < NIMG; i++) pix[i] <= '0;
    end else if (accept) begin
      beat <= (beat == 4'(NBEAT - 1)) ? 4'd0 : beat + 4'd1;
      if (beat < 4'(KW)) tap[beat[1:0]] <= bus.in_data;
      else               pix[pix_wr]    <= bus.in_data;
    end
  end

  cnn1d_result_buffer u_result_buffer (
    .clk         (clk),
    .reset       (reset),
    .read_en     (read_en_q),
    .conv_result (bus.conv_result),
    .drain       (draining),
    .res_ready   (bus.res_ready),
    .res_valid   (bus.res_valid),
    .res_data    (bus.res_data),
    .res_last    (bus.res_last),
    .drain_done  (drain_done)
  );

  assign bus.in_ready    = (state == LOAD);
  assign bus.cnn_start   = start_q;
  assign bus.cnn_read_en = read_en_q;
  assign bus.cnn_image   = image_q;
  assign bus.cnn_filter  = filter_q;
  assign busy            = (state != LOAD);
  assign dbg_state       = state;

endmodule

// File: tb/tb_cnn1d_frame_sequencer.sv
// Directed bench for cnn1d_frame_sequencer with a behavioural CNN datapath.
module tb_cnn1d_frame_sequencer;
  import cnn1d_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   busy;
  state_t dbg_state;

  int vecs = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt;
  int read_cnt;
  logic [RW-1:0] exp_q[$];

  cnn1d_frame_sequencer_if bus ();

  cnn1d_frame_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- CNN datapath model ----------------
  // 15-entry product RF written in order; read r sums entries 3r..3r+2 via a
  // read register then an adder register, so the sum is visible 2 cycles on.
  logic [RW-1:0] rf [NPROD];
  int            wr_ptr;
  int            rd_ptr;
  logic [RW-1:0] p0, p1, p2;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr          <= 0;
      rd_ptr          <= 0;
      p0              <= '0;
      p1              <= '0;
      p2              <= '0;
      bus.conv_result <= '0;
    end else begin
      if (bus.cnn_start) begin
        rf[wr_ptr] <= RW'(bus.cnn_image) * RW'(bus.cnn_filter);
        wr_ptr     <= (wr_ptr == NPROD - 1) ? 0 : wr_ptr + 1;
      end
      if (bus.cnn_read_en) begin
        p0     <= rf[3 * rd_ptr];
        p1     <= rf[3 * rd_ptr + 1];
        p2     <= rf[3 * rd_ptr + 2];
        rd_ptr <= (rd_ptr == NOUT - 1) ? 0 : rd_ptr + 1;
      end else begin
        p0 <= '0;
        p1 <= '0;
        p2 <= '0;
      end
      bus.conv_result <= p0 + p1 + p2;
    end
  end

  // Pulse counters for frame accounting.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_cnt <= 0;
      read_cnt  <= 0;
    end else begin
      if (bus.cnn_start)   start_cnt <= start_cnt + 1;
      if (bus.cnn_read_en) read_cnt  <= read_cnt + 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag, input int waited);
    vecs++;
    fails++;
    $error("FAIL %s: observed no event after %0d cycles expected event", tag, waited);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input bit gap);
    int bound;
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bound = 0;
    while (!bus.in_ready && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 100) timeout_fail("in_ready_wait", bound);
  endtask

  // Sends taps then pixels; returns at the first negedge after the last beat.
  task automatic send_frame(input logic [DW-1:0] t0, t1, t2,
                            input logic [DW-1:0] px [NIMG],
                            input bit gaps, output int first_cyc);
    logic [DW-1:0] beats [NBEAT];
    beats[0] = t0;
    beats[1] = t1;
    beats[2] = t2;
    for (int i = 0; i < NIMG; i++) beats[KW + i] = px[i];
    first_cyc = -1;
    for (int i = 0; i < NBEAT; i++) begin
      send_beat(beats[i], gaps && (i % 2 == 1));
      if (i == 0) first_cyc = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Pulls five results, comparing against exp_q; optional 10-cycle stall.
  task automatic collect(input int stall_idx, output int first_cyc);
    logic [RW-1:0] e;
    int bound;
    first_cyc = -1;
    for (int i = 0; i < NOUT; i++) begin
      bound = 0;
      while (!bus.res_valid && bound < 200) begin
        @(negedge clk);
        bound++;
      end
      if (bound >= 200) begin
        timeout_fail("res_valid_wait", bound);
        return;
      end
      if (i == 0) first_cyc = cyc;
      e = exp_q.pop_front();
      if (i == stall_idx) begin
        bus.res_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("res_data_hold", 32'(bus.res_data), 32'(e));
          check("res_valid_hold", 32'(bus.res_valid), 1);
        end
        bus.res_ready = 1'b1;
      end
      check("res_data", 32'(bus.res_data), 32'(e));
      check("res_last", 32'(bus.res_last), 32'(i == NOUT - 1));
      check("busy_drain", 32'(busy), 1);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(LOAD));
  endtask

  task automatic check_counts(input string tag, input int s0, input int r0);
    check({tag, "_start_cycles"}, 32'(start_cnt - s0), 15);
    check({tag, "_read_cycles"}, 32'(read_cnt - r0), 5);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DW-1:0] px_up   [NIMG];
    logic [DW-1:0] px_down [NIMG];
    logic [DW-1:0] px_max  [NIMG];
    int t_first, t_res, s0, r0;

    px_up   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    px_down = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    px_max  = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b1;
    reset         = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_cnn_start", 32'(bus.cnn_start), 0);
    check("rst_cnn_image", 32'(bus.cnn_image), 0);
    check("rst_cnn_filter", 32'(bus.cnn_filter), 0);
    check("rst_cnn_read_en", 32'(bus.cnn_read_en), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    check("rst_res_last", 32'(bus.res_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(LOAD));
    reset = 1'b1;

    // Basic frame: taps 1,2,3, pixels 1..7.
    s0 = start_cnt;
    r0 = read_cnt;
    exp_q.push_back(10'd14); exp_q.push_back(10'd20); exp_q.push_back(10'd26);
    exp_q.push_back(10'd32); exp_q.push_back(10'd38);
    send_frame(4'd1, 4'd2, 4'd3, px_up, 1'b0, t_first);
    check("write_state", 32'(dbg_state), 32'(WRITE));
    check("write_in_ready", 32'(bus.in_ready), 0);
    check("write_busy", 32'(busy), 1);
    check("n0_start", 32'(bus.cnn_start), 1);
    check("n0_image", 32'(bus.cnn_image), 1);
    check("n0_filter", 32'(bus.cnn_filter), 1);
    @(negedge clk);
    check("n1_image", 32'(bus.cnn_image), 2);
    check("n1_filter", 32'(bus.cnn_filter), 2);
    @(negedge clk);
    check("n2_image", 32'(bus.cnn_image), 3);
    check("n2_filter", 32'(bus.cnn_filter), 3);
    @(negedge clk);
    check("n3_image", 32'(bus.cnn_image), 2);
    check("n3_filter", 32'(bus.cnn_filter), 1);
    collect(-1, t_res);
    check("basic_latency", 32'(t_res - t_first), 32);
    check_counts("basic", s0, r0);
    check_idle("basic_end");

    // Max values: every product 225, every result 675.
    s0 = start_cnt;
    r0 = read_cnt;
    repeat (NOUT) exp_q.push_back(10'd675);
    send_frame(4'd15, 4'd15, 4'd15, px_max, 1'b0, t_first);
    collect(-1, t_res);
    check("max_latency", 32'(t_res - t_first), 32);
    check_counts("max", s0, r0);

    // Back-to-back frames A then B.
    s0 = start_cnt;
    r0 = read_cnt;
    exp_q.push_back(10'd14); exp_q.push_back(10'd20); exp_q.push_back(10'd26);
    exp_q.push_back(10'd32); exp_q.push_back(10'd38);
    send_frame(4'd1, 4'd2, 4'd3, px_up, 1'b0, t_first);
    collect(-1, t_res);
    exp_q.push_back(10'd6); exp_q.push_back(10'd5); exp_q.push_back(10'd4);
    exp_q.push_back(10'd3); exp_q.push_back(10'd2);
    send_frame(4'd0, 4'd1, 4'd0, px_down, 1'b0, t_first);
    collect(-1, t_res);
    check("b2b_start_cycles", 32'(start_cnt - s0), 30);
    check("b2b_read_cycles", 32'(read_cnt - r0), 10);

    // Backpressure: gapped input and a 10-cycle stall at y[2].
    s0 = start_cnt;
    r0 = read_cnt;
    exp_q.push_back(10'd14); exp_q.push_back(10'd20); exp_q.push_back(10'd26);
    exp_q.push_back(10'd32); exp_q.push_back(10'd38);
    send_frame(4'd1, 4'd2, 4'd3, px_up, 1'b1, t_first);
    collect(2, t_res);
    check_counts("bp", s0, r0);
    check_idle("bp_end");

    // Reset in the middle of WRITE (n=7), then a clean basic frame.
    send_frame(4'd1, 4'd2, 4'd3, px_up, 1'b0, t_first);
    repeat (7) @(negedge clk);
    check("n7_start", 32'(bus.cnn_start), 1);
    check("n7_image", 32'(bus.cnn_image), 4);
    check("n7_filter", 32'(bus.cnn_filter), 2);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    check("midrst_cnn_start", 32'(bus.cnn_start), 0);
    check("midrst_cnn_image", 32'(bus.cnn_image), 0);
    check("midrst_cnn_filter", 32'(bus.cnn_filter), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_state", 32'(dbg_state), 32'(LOAD));
    @(negedge clk);
    reset = 1'b1;
    s0 = start_cnt;
    r0 = read_cnt;
    exp_q.push_back(10'd14); exp_q.push_back(10'd20); exp_q.push_back(10'd26);
    exp_q.push_back(10'd32); exp_q.push_back(10'd38);
    send_frame(4'd1, 4'd2, 4'd3, px_up, 1'b0, t_first);
    collect(-1, t_res);
    check("post_rst_latency", 32'(t_res - t_first), 32);
    check_counts("post_rst", s0, r0);
    check_idle("post_rst_end");

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
